if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: NOP_INST, 32'h00000013, value driven on inst_o at reset and after flush.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ce  input  1  fetch enable from PC generator; 0 = no requests accepted.
REQ-005 pc  input  32  byte address of instruction to fetch.
REQ-006 jumpout  input  1  branch/jump redirect from execute; flushes the in-flight fetch.
REQ-007 stall  input  CtrlWidth  pipeline stall vector; bit IF_BIT holds the fetch stage.
REQ-008 mem_rd  output  1  byte-read request to memory port.
REQ-009 mem_addr  output  32  byte address of current memory read.
REQ-010 mem_din  input  8  read data byte, valid when mem_ack=1.
REQ-011 mem_ack  input  1  one-cycle strobe; mem_din holds the byte for the pending mem_addr.
REQ-012 inst_o  output  32  assembled instruction to IF/ID register.
REQ-013 inst_pc_o  output  32  address of inst_o.
REQ-014 inst_valid  output  1  inst_o/inst_pc_o are valid this cycle.
REQ-015 if_busy  output  1  stall request to controller; 1 while a fetch is in progress.

Function
REQ-016 FSM states SHALL be IDLE, RD0, RD1, RD2, RD3, DONE.
REQ-017 IDLE: if ce=1, jumpout=0 and stall[IF_BIT]=0, latch pc into req_pc and go to RD0 next cycle; otherwise stay IDLE.
REQ-018 RDn (n=0..3): mem_rd=1, mem_addr=req_pc+n; on mem_ack write mem_din into instruction bits [8n+7:8n] (little-endian) and advance; without mem_ack hold state and address indefinitely.
REQ-019 RD3 with mem_ack SHALL go to DONE; inst_o, inst_pc_o=req_pc, inst_valid=1 registered so they are visible the cycle DONE is entered.
REQ-020 DONE: if stall[IF_BIT]=0, go IDLE next cycle and drop inst_valid; if stall[IF_BIT]=1, stay DONE holding all outputs unchanged.
REQ-021 Minimum latency from IDLE acceptance to inst_valid SHALL be 5 cycles with mem_ack returned every cycle.
REQ-022 jumpout=1 in any state SHALL force IDLE next cycle, inst_valid=0, inst_o=NOP_INST, mem_rd=0; a mem_ack coincident with jumpout SHALL be discarded.
REQ-023 jumpout has priority over mem_ack and stall; stall has no effect in RD0..RD3 (memory transaction completes).
REQ-024 mem_rd SHALL be 0 in IDLE and DONE; mem_addr SHALL wrap modulo 2^32 (req_pc=32'hFFFFFFFE reads FFFFFFFE, FFFFFFFF, 0, 1).
REQ-025 if_busy SHALL be 1 in RD0..RD3, 0 in IDLE and DONE.
REQ-026 pc changes while not in IDLE SHALL be ignored; only req_pc is used.

Reset
REQ-027 rst=0 SHALL immediately force: state IDLE, mem_rd=0, mem_addr=0, inst_o=NOP_INST, inst_pc_o=0, inst_valid=0, if_busy=0, req_pc=0, reuse-valid=0, regardless of state mid-fetch.
REQ-028 First acceptance SHALL occur no earlier than the first posedge after rst returns to 1.

Configuration
REQ-029 Macro IF_REUSE_EN: when defined, a one-entry tag (last_pc, last_inst, last_ok) SHALL be kept; an IDLE acceptance with pc==last_pc and last_ok=1 goes directly to DONE next cycle with inst_o=last_inst, no memory read (latency 1).
REQ-030 last_ok SHALL be set on every RD3 completion and cleared by reset and by jumpout aborting a fetch; without IF_REUSE_EN every fetch performs four byte reads and no tag storage exists.

Structure
REQ-031 CtrlWidth, IF_BIT, Stop, ZeroWord and FSM state encodings SHALL reside in the shared defines file; NOP_INST default also defined there.
REQ-032 Single module; no sub-module required; optional reuse tag stays inline under the macro.

Verification
REQ-033 Reset mid-RD2 (rst=0 one cycle) -> next cycle state IDLE, inst_valid=0, inst_o=32'h00000013, mem_rd=0.
REQ-034 pc=32'h00000100, ack every cycle, bytes 13,05,A0,00 -> inst_valid=1 at cycle 5, inst_o=32'h00A00513, inst_pc_o=32'h100, mem_addr sequence 100..103.
REQ-035 Same fetch with mem_ack delayed 3 cycles on byte 1 -> mem_addr held 101, result identical at cycle 8.
REQ-036 jumpout=1 during RD1 with coincident mem_ack -> IDLE next cycle, no inst_valid, next fetch of pc=32'h200 proceeds normally.
REQ-037 stall[IF_BIT]=1 in DONE for 4 cycles -> inst_valid and inst_o held 4 cycles, IDLE on release.
REQ-038 IF_REUSE_EN defined, refetch pc=32'h100 -> inst_valid after 1 cycle, mem_rd never asserted; after jumpout abort, refetch issues four reads.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module   : if_fetch_pkg
// Brief    : Shared control-vector widths, stall decode and fetch FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

  localparam int          CtrlWidth        = 6;
  localparam int          IF_BIT           = 1;
  localparam logic        Stop             = 1'b1;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    DONE = 3'd5
  } fetch_state_e;

  function automatic logic is_rd_state(input fetch_state_e s);
    return (s == RD0) || (s == RD1) || (s == RD2) || (s == RD3);
  endfunction

  // Byte offset from req_pc that a read state targets.
  function automatic logic [1:0] rd_offset(input fetch_state_e s);
    logic [1:0] off;
    off = 2'd0;
    case (s)
      RD1:     off = 2'd1;
      RD2:     off = 2'd2;
      RD3:     off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Brief    : Byte-serial instruction fetch (four little-endian byte reads per
//            instruction). Define IF_REUSE_EN for a one-entry reuse tag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [31:0]          pc,
  input  logic                 jumpout,
  input  logic [CtrlWidth-1:0] stall,
  output logic                 mem_rd,
  output logic [31:0]          mem_addr,
  input  logic [7:0]           mem_din,
  input  logic                 mem_ack,
  output logic [31:0]          inst_o,
  output logic [31:0]          inst_pc_o,
  output logic                 inst_valid,
  output logic                 if_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [23:0]  inst_buf_q, inst_buf_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;

  logic         stall_if;
  logic         rd_active;
  logic         unused_stall;
  logic [31:0]  fetched_word;

  assign stall_if     = (stall[IF_BIT] == Stop);
  assign unused_stall = ^stall;
  assign rd_active    = is_rd_state(state_q);
  assign fetched_word = {mem_din, inst_buf_q};

`ifdef IF_REUSE_EN
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] last_inst_q, last_inst_d;
  logic        last_ok_q, last_ok_d;
  logic        reuse_hit;

  assign reuse_hit = last_ok_q && (pc == last_pc_q);
`endif

  // Memory port is a pure decode of the current read state and latched PC.
  assign mem_rd     = rd_active;
  assign mem_addr   = rd_active ? (req_pc_q + {30'd0, rd_offset(state_q)}) : ZeroWord;
  assign if_busy    = rd_active;
  assign inst_o     = inst_q;
  assign inst_pc_o  = inst_pc_q;
  assign inst_valid = inst_valid_q;

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    inst_buf_d   = inst_buf_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    // A redirect beats everything, including an ack landing in the same cycle.
    if (jumpout) begin
      state_d      = IDLE;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end else begin
      case (state_q)
        IDLE: begin
          if (ce && !stall_if) begin
            req_pc_d = pc;
`ifdef IF_REUSE_EN
            if (reuse_hit) begin
              state_d      = DONE;
              inst_d       = last_inst_q;
              inst_pc_d    = pc;
              inst_valid_d = 1'b1;
            end else begin
              state_d = RD0;
            end
`else
            state_d = RD0;
`endif
          end
        end
        RD0: begin
          if (mem_ack) begin
            inst_buf_d[7:0] = mem_din;
            state_d         = RD1;
          end
        end
        RD1: begin
          if (mem_ack) begin
            inst_buf_d[15:8] = mem_din;
            state_d          = RD2;
          end
        end
        RD2: begin
          if (mem_ack) begin
            inst_buf_d[23:16] = mem_din;
            state_d           = RD3;
          end
        end
        RD3: begin
          if (mem_ack) begin
            inst_d       = fetched_word;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = DONE;
          end
        end
        DONE: begin
          if (!stall_if) begin
            state_d      = IDLE;
            inst_valid_d = 1'b0;
          end
        end
        default: begin
          state_d      = IDLE;
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_pc_q     <= ZeroWord;
      inst_buf_q   <= 24'd0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= ZeroWord;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      inst_buf_q   <= inst_buf_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef IF_REUSE_EN
  // Tag is armed by each completed four-byte read and dropped when a read is aborted.
  always_comb begin
    last_pc_d   = last_pc_q;
    last_inst_d = last_inst_q;
    last_ok_d   = last_ok_q;
    if (jumpout) begin
      if (rd_active) begin
        last_ok_d = 1'b0;
      end
    end else if ((state_q == RD3) && mem_ack) begin
      last_pc_d   = req_pc_q;
      last_inst_d = fetched_word;
      last_ok_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pc_q   <= ZeroWord;
      last_inst_q <= NOP_INST;
      last_ok_q   <= 1'b0;
    end else begin
      last_pc_q   <= last_pc_d;
      last_inst_q <= last_inst_d;
      last_ok_q   <= last_ok_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Scoreboard bench for if_fetch with a byte-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;
  import if_fetch_pkg::CtrlWidth;
  import if_fetch_pkg::IF_BIT;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ce;
  logic [31:0]          pc;
  logic                 jumpout;
  logic [CtrlWidth-1:0] stall;
  logic                 mem_rd;
  logic [31:0]          mem_addr;
  logic [7:0]           mem_din;
  logic                 mem_ack;
  logic [31:0]          inst_o;
  logic [31:0]          inst_pc_o;
  logic                 inst_valid;
  logic                 if_busy;

  if_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .jumpout   (jumpout),
    .stall     (stall),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack),
    .inst_o    (inst_o),
    .inst_pc_o (inst_pc_o),
    .inst_valid(inst_valid),
    .if_busy   (if_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          fast_mode = 1'b1;
  int          slow_byte = -1;
  logic [31:0] last_pc_m = 32'h0;
  bit          last_ok_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference memory: a few fixed bytes, everything else a hash of the address.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'h0000_0100: b = 8'h13;
      32'h0000_0101: b = 8'h05;
      32'h0000_0102: b = 8'hA0;
      32'h0000_0103: b = 8'h00;
      default:       b = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A ^ {a[3:0], a[7:4]};
    endcase
    return b;
  endfunction

  function automatic logic [31:0] expect_inst(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return last_ok_m && (a == last_pc_m);
  endfunction

  function automatic logic [CtrlWidth-1:0] rand_stall(input bit if_bit);
    logic [CtrlWidth-1:0] s;
    s = CtrlWidth'($urandom);
    s[IF_BIT] = if_bit;
    return s;
  endfunction

  // Memory responder: acks with model bytes and checks every requested address.
  initial begin
    bit have_wait;
    int wait_left;
    mem_ack   = 1'b0;
    mem_din   = 8'h00;
    have_wait = 1'b0;
    wait_left = 0;
    forever begin
      @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_rd) begin
        if (!have_wait) begin
          if (fast_mode) wait_left = ((4 - addr_q.size()) == slow_byte) ? 3 : 0;
          else wait_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
          have_wait = 1'b1;
        end
        if (!jumpout) begin
          if (addr_q.size() == 0) fail_now("unexpected_read", $sformatf("mem_rd at addr %h", mem_addr));
          else chk("mem_addr", mem_addr, addr_q[0]);
        end
        if (wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_din   = mem_byte(mem_addr);
          have_wait = 1'b0;
          if (!jumpout && addr_q.size() > 0) void'(addr_q.pop_front());
        end else begin
          wait_left--;
        end
      end else begin
        have_wait = 1'b0;
      end
    end
  end

  // Monitor: per-cycle protocol rules and scoreboard pop on each new result.
  initial begin
    bit          pv, j, s, r;
    logic [31:0] pi, pp;
    exp_t        e;
    pv = 1'b0;
    pi = 32'h0;
    pp = 32'h0;
    forever begin
      @(posedge clk);
      j = jumpout;
      s = stall[IF_BIT];
      r = rst;
      #1;
      if (!r || !rst) begin
        pv = 1'b0;
        continue;
      end
      chk("busy_eq_rd", {31'd0, if_busy}, {31'd0, mem_rd});
      if (j) begin
        chk("jump_valid", {31'd0, inst_valid}, 32'd0);
        chk("jump_inst", inst_o, NOP);
        chk("jump_rd", {31'd0, mem_rd}, 32'd0);
      end else if (pv && s) begin
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_inst", inst_o, pi);
        chk("hold_pc", inst_pc_o, pp);
      end else if (pv) begin
        chk("release_valid", {31'd0, inst_valid}, 32'd0);
      end
      if (inst_valid && !pv) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_valid", $sformatf("inst %h pc %h with nothing pending", inst_o, inst_pc_o));
        end else begin
          e = exp_q.pop_front();
          chk("inst_o", inst_o, e.inst);
          chk("inst_pc_o", inst_pc_o, e.pc);
        end
      end
      pv = inst_valid;
      pi = inst_o;
      pp = inst_pc_o;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((if_busy || inst_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_now("idle_timeout", "fetch unit never returned idle");
  endtask

  task automatic start_fetch(input logic [31:0] a, output bit hit);
    exp_t e;
    hit     = is_hit(a);
    ce      = 1'b1;
    pc      = a;
    jumpout = 1'b0;
    stall   = rand_stall(1'b0);
    e.inst  = expect_inst(a);
    e.pc    = a;
    exp_q.push_back(e);
    if (!hit) for (int i = 0; i < 4; i++) addr_q.push_back(a + 32'(i));
    @(negedge clk);
    ce = 1'b0;
    pc = $urandom;
  endtask

  // exp_lat > 0 checks the cycles from the request to inst_valid for a miss.
  task automatic do_fetch(input logic [31:0] a, input int hold, input int abort_at, input int exp_lat);
    int k;
    bit hit, done;
    wait_idle();
    start_fetch(a, hit);
    k    = 1;
    done = 1'b0;
    while (!done) begin
      if (inst_valid) begin
        if (exp_lat > 0) chk("latency", 32'(k), hit ? 32'd1 : 32'(exp_lat));
        if (!hit) begin
          last_pc_m = a;
          last_ok_m = REUSE;
        end
        for (int i = 0; i < hold; i++) begin
          stall = rand_stall(1'b1);
          pc    = $urandom;
          @(negedge clk);
        end
        stall = rand_stall(1'b0);
        @(negedge clk);
        done = 1'b1;
      end else if (k == abort_at && if_busy) begin
        jumpout = 1'b1;
        void'(exp_q.pop_back());
        addr_q.delete();
        last_ok_m = 1'b0;
        @(negedge clk);
        jumpout = 1'b0;
        done    = 1'b1;
      end else if (k > 200) begin
        fail_now("fetch_timeout", $sformatf("no inst_valid for pc %h", a));
        exp_q.delete();
        addr_q.delete();
        done = 1'b1;
      end else begin
        stall = rand_stall(1'($urandom_range(0, 1)));
        pc    = $urandom;
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic reset_mid_fetch(input logic [31:0] a);
    bit hit;
    wait_idle();
    last_ok_m = 1'b0;
    start_fetch(a, hit);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    addr_q.delete();
    #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_busy", {31'd0, if_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, if_busy}, 32'd0);
    chk("post_rst_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, prev_a;
    rst     = 1'b1;
    ce      = 1'b0;
    pc      = 32'h0;
    jumpout = 1'b0;
    stall   = '0;
    #2 rst  = 1'b0;
    ce      = 1'b1;
    pc      = 32'h40;
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_inst", inst_o, NOP);
    chk("reset_inst_pc", inst_pc_o, 32'd0);
    chk("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_busy", {31'd0, if_busy}, 32'd0);
    ce  = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    fast_mode = 1'b1;
    slow_byte = -1;
    do_fetch(32'h0000_0100, 0, -1, 5);
    slow_byte = 1;
    do_fetch(32'h0000_0100, 0, -1, 8);
    slow_byte = -1;
    do_fetch(32'h0000_0300, 0, 2, 0);
    do_fetch(32'h0000_0200, 0, -1, 5);
    do_fetch(32'h0000_0100, 4, -1, 5);
    do_fetch(32'h0000_0100, 0, -1, 5);
    do_fetch(32'h0000_0400, 0, 2, 0);
    do_fetch(32'h0000_0100, 0, -1, 5);
    do_fetch(32'hFFFF_FFFE, 1, -1, 5);
    reset_mid_fetch(32'h0000_0100);
    do_fetch(32'h0000_0100, 0, -1, 5);

    fast_mode = 1'b0;
    prev_a    = 32'h0000_0100;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = prev_a;
        2:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      do_fetch(a, int'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : -1, 0);
      prev_a = a;
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
